combo_entry: RTL and testbench

Sequential code-entry front end for the encoded lock. It collects three "set" digits and then three "confirm" digits from a single digit bus and an ENTER strobe. Once all six are held, it presents them on six parallel 5-bit outputs and pulses LOAD to the combination checker. It then samples the checker's registered result on the following cycle and decides match, retry or lockout.

---
 rtl/combo_entry.sv | 149 ++++++++++++++
 tb/tb_combo_entry.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/combo_entry.sv
// combo_entry: collects three "set" digits and three "confirm" digits, hands
// them to the combination checker with a LOAD strobe, then acts on its result
// (match, retry, or lockout after repeated mismatches).
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no digits held, waiting for the first ENTER
//   ENTRY   | 1-5 digits held, timeout counter running
//   LOAD    | all six digits held, LOAD strobe high for this cycle
//   RESULT  | checker result RES sampled at the end of this cycle
//   DONE    | combination matched, MATCH high until CLEAR
//   LOCKOUT | too many consecutive mismatches, inputs ignored until expiry
module combo_entry #(
  parameter int DIGIT_MAX      = 9,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 100_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] DIGIT,
  input  logic       ENTER,
  input  logic       CLEAR,
  input  logic       RES,
  output logic [4:0] CHK1,
  output logic [4:0] CHK2,
  output logic [4:0] CHK3,
  output logic [4:0] CHK4,
  output logic [4:0] CHK5,
  output logic [4:0] CHK6,
  output logic       LOAD,
  output logic [2:0] COUNT,
  output logic       MATCH,
  output logic       FAIL,
  output logic       ERR,
  output logic       LOCKED
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FC_W = $clog2(MAX_FAIL + 1);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_MAX  = FC_W'(MAX_FAIL);
  localparam logic [4:0]      DIG_MAX = 5'(DIGIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_LOAD, S_RESULT, S_DONE, S_LOCKOUT
  } state_t;

  state_t          state, state_nxt;
  logic [4:0]      chk [6];
  logic [2:0]      count;
  logic [TO_W-1:0] to_cnt;
  logic [LK_W-1:0] lk_cnt;
  logic [FC_W-1:0] fail_cnt, fail_inc;
  logic            err_q, fail_q;
  logic            in_entry, take_digit, reject_digit, to_expire, lk_expire;

  // Qualify the ENTER/CLEAR strobes and the counter terminal counts.
  always_comb begin
    in_entry     = (state == S_IDLE) || (state == S_ENTRY);
    take_digit   = in_entry && ENTER && !CLEAR && (DIGIT <= DIG_MAX);
    reject_digit = in_entry && ENTER && !CLEAR && (DIGIT > DIG_MAX);
    // An ENTER landing on the expiry cycle wins over the timeout.
    to_expire    = (state == S_ENTRY) && !ENTER && (to_cnt == TO_LAST);
    lk_expire    = (state == S_LOCKOUT) && (lk_cnt == LK_LAST);
    fail_inc     = (fail_cnt == FC_MAX) ? fail_cnt : fail_cnt + FC_W'(1);
  end

  // State register; reset drops LOAD/MATCH/LOCKED immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_ENTRY: begin
        if (CLEAR)           state_nxt = S_IDLE;
        else if (take_digit) state_nxt = (count == 3'd5) ? S_LOAD : S_ENTRY;
        else if (to_expire)  state_nxt = S_IDLE;
      end
      S_LOAD:   state_nxt = S_RESULT;
      S_RESULT: begin
        if (RES)                     state_nxt = S_DONE;
        else if (fail_inc == FC_MAX) state_nxt = S_LOCKOUT;
        else                         state_nxt = S_IDLE;
      end
      S_DONE:    if (CLEAR) state_nxt = S_IDLE;
      S_LOCKOUT: if (lk_expire) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Digit storage, pulse registers and the timeout/lockout/fail counters.
  // Every path into IDLE or LOCKOUT discards the held digits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 6; i++) chk[i] <= '0;
      count    <= '0;
      to_cnt   <= '0;
      lk_cnt   <= '0;
      fail_cnt <= '0;
      err_q    <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      err_q  <= reject_digit;
      fail_q <= (state == S_RESULT) && !RES;

      if (state_nxt == S_IDLE || state_nxt == S_LOCKOUT) begin
        for (int i = 0; i < 6; i++) chk[i] <= '0;
        count <= '0;
      end else if (take_digit) begin
        for (int i = 0; i < 6; i++)
          if (count == 3'(i)) chk[i] <= DIGIT;
        count <= count + 3'd1;
      end

      to_cnt <= (state == S_ENTRY && state_nxt == S_ENTRY && !ENTER)
                ? to_cnt + TO_W'(1) : '0;
      lk_cnt <= (state == S_LOCKOUT && state_nxt == S_LOCKOUT)
                ? lk_cnt + LK_W'(1) : '0;

      if (state == S_RESULT) fail_cnt <= RES ? '0 : fail_inc;
      else if (lk_expire)    fail_cnt <= '0;
    end
  end

  // Output decode from registered state and pulse flops.
  always_comb begin
    LOAD   = (state == S_LOAD);
    MATCH  = (state == S_DONE);
    LOCKED = (state == S_LOCKOUT);
    ERR    = err_q;
    FAIL   = fail_q;
    COUNT  = count;
    CHK1   = chk[0];
    CHK2   = chk[1];
    CHK3   = chk[2];
    CHK4   = chk[3];
    CHK5   = chk[4];
    CHK6   = chk[5];
  end

endmodule

// File: tb/tb_combo_entry.sv
// Bench for combo_entry: stimulus pushes expected output events into a queue,
// a monitor on the falling clock edge pops and compares them as they appear.
module tb_combo_entry;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [4:0] DIGIT;
  logic       ENTER, CLEAR, RES;
  logic [4:0] CHK1, CHK2, CHK3, CHK4, CHK5, CHK6;
  logic       LOAD, MATCH, FAIL, ERR, LOCKED;
  logic [2:0] COUNT;

  combo_entry #(
    .DIGIT_MAX(9), .TIMEOUT_CYCLES(10), .MAX_FAIL(3), .LOCKOUT_CYCLES(20)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .DIGIT(DIGIT), .ENTER(ENTER), .CLEAR(CLEAR),
    .RES(RES), .CHK1(CHK1), .CHK2(CHK2), .CHK3(CHK3), .CHK4(CHK4),
    .CHK5(CHK5), .CHK6(CHK6), .LOAD(LOAD), .COUNT(COUNT), .MATCH(MATCH),
    .FAIL(FAIL), .ERR(ERR), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  localparam int K_LOAD = 0, K_MATCH = 1, K_FAIL = 2, K_ERR = 3, K_LOCK = 4;

  typedef struct {
    int          kind;
    int          val;
    logic [29:0] chk;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  logic match_q = 1'b0;
  logic lock_q  = 1'b0;
  int  lk_len   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [29:0] chk_all();
    return {CHK1, CHK2, CHK3, CHK4, CHK5, CHK6};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int v, input logic [29:0] c);
    ev_t e;
    e.kind = k; e.val = v; e.chk = c;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input int k, input int v, input logic [29:0] c);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d val %0d, none expected (t=%0t)", k, v, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != v || (k == K_LOAD && e.chk != c)) begin
        errors++;
        $display("FAIL event: got kind %0d val %0d chk %h, expected kind %0d val %0d chk %h (t=%0t)",
                 k, v, c, e.kind, e.val, e.chk, $time);
      end
    end
  endtask

  // Monitor: turn observed pulses/levels into events and score them.
  always @(negedge CLK) begin
    if (LOAD === 1'b1) expect_ev(K_LOAD, cyc, chk_all());
    if (FAIL === 1'b1) expect_ev(K_FAIL, cyc, '0);
    if (ERR  === 1'b1) expect_ev(K_ERR, cyc, '0);
    if (MATCH === 1'b1 && !match_q) expect_ev(K_MATCH, cyc, '0);
    match_q = (MATCH === 1'b1);
    if (LOCKED === 1'b1) lk_len++;
    else if (lock_q) begin
      expect_ev(K_LOCK, lk_len, '0);
      lk_len = 0;
    end
    lock_q = (LOCKED === 1'b1);
  end

  task automatic drive(input bit en, input bit clr, input logic [4:0] d);
    DIGIT = d; ENTER = en; CLEAR = clr;
    @(posedge CLK); #1;
    ENTER = 1'b0; CLEAR = 1'b0;
  endtask

  task automatic do_enter(input logic [4:0] d);
    drive(1'b1, 1'b0, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 5'd0);
  endtask

  // Full six-digit attempt; returns in the cycle after RESULT.
  task automatic entry6(input logic [29:0] digs, input bit res);
    int e;
    RES = res;
    for (int i = 0; i < 6; i++) do_enter(digs[29-5*i -: 5]);
    e = cyc;
    push(K_LOAD, e, digs);
    push(res ? K_MATCH : K_FAIL, e + 2, '0);
    idle(2);
  endtask

  localparam logic [29:0] SEQ_OK  = {5'd4, 5'd2, 5'd7, 5'd4, 5'd2, 5'd7};
  localparam logic [29:0] SEQ_BAD = {5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd4};

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; DIGIT = '0; ENTER = 1'b0; CLEAR = 1'b0; RES = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_load", LOAD, 0);
    check("rst_match", MATCH, 0);
    check("rst_fail", FAIL, 0);
    check("rst_err", ERR, 0);
    check("rst_locked", LOCKED, 0);
    check("rst_count", COUNT, 0);
    check("rst_chk", chk_all(), 0);
    RST_N = 1'b1;

    // Matching entry, ENTER ignored in DONE, CLEAR leaves DONE.
    entry6(SEQ_OK, 1'b1);
    check("done_match", MATCH, 1);
    check("done_count", COUNT, 6);
    check("done_chk", chk_all(), SEQ_OK);
    do_enter(5'd3);
    check("done_ignore_count", COUNT, 6);
    check("done_ignore_chk", chk_all(), SEQ_OK);
    drive(1'b0, 1'b1, 5'd0);
    check("clear_match", MATCH, 0);
    check("clear_count", COUNT, 0);
    check("clear_chk", chk_all(), 0);

    // Three mismatches lead to lockout.
    for (int a = 0; a < 3; a++) begin
      if (a == 2) begin
        entry6(SEQ_BAD, 1'b0);
        push(K_LOCK, 20, '0);
      end else begin
        entry6(SEQ_BAD, 1'b0);
      end
      check("mis_count", COUNT, 0);
      check("mis_chk", chk_all(), 0);
      check("mis_locked", LOCKED, (a == 2) ? 1 : 0);
    end
    do_enter(5'd12);
    check("lock_ignore_count", COUNT, 0);
    idle(25);
    check("lock_released", LOCKED, 0);

    // Fail counter cleared by lockout expiry: one more mismatch, no lockout.
    entry6(SEQ_BAD, 1'b0);
    idle(1);
    check("post_lock_locked", LOCKED, 0);
    check("post_lock_count", COUNT, 0);

    // Rejected digit at COUNT=2.
    do_enter(5'd1);
    do_enter(5'd2);
    do_enter(5'd12);
    push(K_ERR, cyc, '0);
    check("err_count", COUNT, 2);
    check("err_chk3", CHK3, 0);
    do_enter(5'd5);
    check("after_err_chk3", CHK3, 5);
    check("after_err_count", COUNT, 3);
    drive(1'b0, 1'b1, 5'd0);
    check("clr_count", COUNT, 0);

    // Timeout after 10 idle cycles, and ENTER on the expiry cycle.
    do_enter(5'd6);
    do_enter(5'd7);
    idle(9);
    check("to_pre_count", COUNT, 2);
    idle(1);
    check("to_count", COUNT, 0);
    check("to_chk12", {CHK1, CHK2}, 0);
    do_enter(5'd6);
    do_enter(5'd7);
    idle(9);
    do_enter(5'd8);
    check("to_race_count", COUNT, 3);
    check("to_race_chk", {CHK1, CHK2, CHK3}, {5'd6, 5'd7, 5'd8});

    // CLEAR beats ENTER at COUNT=4.
    do_enter(5'd1);
    check("pre_clr_count", COUNT, 4);
    drive(1'b1, 1'b1, 5'd9);
    check("clr_enter_count", COUNT, 0);
    check("clr_enter_chk", chk_all(), 0);

    // Asynchronous reset while LOAD is high.
    RES = 1'b1;
    for (int i = 0; i < 6; i++) do_enter(SEQ_OK[29-5*i -: 5]);
    #1;
    check("pre_rst_load", LOAD, 1);
    RST_N = 1'b0;
    #1;
    check("async_load", LOAD, 0);
    check("async_count", COUNT, 0);
    check("async_match", MATCH, 0);
    check("async_chk", chk_all(), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Recovery after reset.
    entry6(SEQ_OK, 1'b1);
    check("recover_match", MATCH, 1);
    drive(1'b0, 1'b1, 5'd0);
    idle(3);
    check("queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
